// File: rtl/conv_encoder_pkg.sv
// Shared constants and helpers for the punctured convolutional encoder:
// default constraint length and generators, rate encodings, puncture periods
// and the per-phase keep pattern.
package conv_encoder_pkg;

    localparam int CONV_K = 7;
    localparam logic [CONV_K-1:0] CONV_G0 = 7'o133;
    localparam logic [CONV_K-1:0] CONV_G1 = 7'o171;

    typedef enum logic [1:0] {
        RATE_1_2     = 2'b00,
        RATE_2_3     = 2'b01,
        RATE_3_4     = 2'b10,
        RATE_1_2_ALT = 2'b11
    } rate_e;

    localparam logic [1:0] PERIOD_1_2 = 2'd1;
    localparam logic [1:0] PERIOD_2_3 = 2'd2;
    localparam logic [1:0] PERIOD_3_4 = 2'd3;

    typedef struct packed {
        logic keep_a;
        logic keep_b;
    } keep_t;

    // Number of input bits in one puncture period for a rate
    function automatic logic [1:0] rate_period(input rate_e rate);
        logic [1:0] period;
        case (rate)
            RATE_2_3: period = PERIOD_2_3;
            RATE_3_4: period = PERIOD_3_4;
            default:  period = PERIOD_1_2;
        endcase
        return period;
    endfunction

    // Which of A/B survive puncturing at a given phase of the period
    function automatic keep_t puncture_keep(input rate_e rate, input logic [1:0] phase);
        keep_t keep;
        keep = '{keep_a: 1'b1, keep_b: 1'b1};
        if (phase == 2'd1 && (rate == RATE_2_3 || rate == RATE_3_4)) begin
            keep = '{keep_a: 1'b1, keep_b: 1'b0};
        end else if (phase == 2'd2 && rate == RATE_3_4) begin
            keep = '{keep_a: 1'b0, keep_b: 1'b1};
        end
        return keep;
    endfunction

endpackage

// File: rtl/punctured_conv_encoder_if.sv
// Streaming bus of the encoder: serial input bits in, serial coded bits out,
// each with its own valid/ready handshake.
interface punctured_conv_encoder_if;
    logic In_Bit;
    logic In_Valid;
    logic In_Ready;
    logic Out_Bit;
    logic Out_Valid;
    logic Out_Ready;

    // Data source and coded-bit sink side
    modport master (
        output In_Bit, In_Valid, Out_Ready,
        input  In_Ready, Out_Bit, Out_Valid
    );

    // Encoder side
    modport slave (
        input  In_Bit, In_Valid, Out_Ready,
        output In_Ready, Out_Bit, Out_Valid
    );
endinterface

// File: rtl/conv_encoder_core.sv
// Convolutional encoder core: K-1 bit state register and the two parity
// outputs A/B. Generator MSB taps the current input, lower bits tap the
// state with the most recent past bit next to the MSB.
module conv_encoder_core
    import conv_encoder_pkg::*;
#(
    parameter int              K  = CONV_K,
    parameter logic [K-1:0]    G0 = CONV_G0,
    parameter logic [K-1:0]    G1 = CONV_G1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic shift_en,
    input  logic in_bit,
    output logic a_bit,
    output logic b_bit
);

    logic [K-2:0] state_reg;
    logic [K-2:0] state_next;
    logic [K-1:0] window;
    logic [K-1:0] taps_a;
    logic [K-1:0] taps_b;

    assign window = {in_bit, state_reg};

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_taps
            assign taps_a[gi] = G0[gi] & window[gi];
            assign taps_b[gi] = G1[gi] & window[gi];
        end
    endgenerate

    assign a_bit = ^taps_a;
    assign b_bit = ^taps_b;

    // Shift the accepted bit in at the top; packet boundary clears history
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = '0;
        end else if (shift_en) begin
            state_next = {in_bit, state_reg[K-2:1]};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
        end else begin
            state_reg <= state_next;
        end
    end

endmodule

// File: rtl/punctured_conv_encoder.sv
// Punctured convolutional encoder top: puncturing, 2-entry pending buffer
// and the input/output handshakes around conv_encoder_core.
// Build option: define CONV_PUNCTURE_EN to support rates 2/3 and 3/4;
// without it the Rate input is ignored and the encoder runs at rate 1/2.
module punctured_conv_encoder
    import conv_encoder_pkg::*;
#(
    parameter int              K  = CONV_K,
    parameter logic [K-1:0]    G0 = CONV_G0,
    parameter logic [K-1:0]    G1 = CONV_G1
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Init,
    input  logic [1:0]               Rate,
    punctured_conv_encoder_if.slave  bus
);

    logic       a_bit;
    logic       b_bit;
    logic       accept;
    logic       out_fire;
    keep_t      keep;
    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic [1:0] buf_reg;      // [0] is the head shown on Out_Bit
    logic [1:0] buf_next;

    assign out_fire     = (count_reg != 2'd0) && bus.Out_Ready;
    assign bus.In_Ready = !Init && ((count_reg == 2'd0) || (count_reg == 2'd1 && out_fire));
    assign accept       = bus.In_Valid && bus.In_Ready;
    assign bus.Out_Valid = (count_reg != 2'd0);
    assign bus.Out_Bit   = buf_reg[0];

    conv_encoder_core #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .clk      (Clock),
        .rst_n    (Reset),
        .clear    (Init),
        .shift_en (accept),
        .in_bit   (bus.In_Bit),
        .a_bit    (a_bit),
        .b_bit    (b_bit)
    );

`ifdef CONV_PUNCTURE_EN
    logic [1:0] phase_reg;
    logic [1:0] phase_next;
    rate_e      rate_reg;
    rate_e      rate_next;
    rate_e      rate_eff;

    // A new rate is only picked up by the first bit of a period
    assign rate_eff = (phase_reg == 2'd0) ? rate_e'(Rate) : rate_reg;
    assign keep     = puncture_keep(rate_eff, phase_reg);

    // Advance the phase per accepted bit, wrapping at the period end
    always_comb begin
        phase_next = phase_reg;
        rate_next  = rate_reg;
        if (Init) begin
            phase_next = 2'd0;
            rate_next  = RATE_1_2;
        end else if (accept) begin
            rate_next  = rate_eff;
            phase_next = (phase_reg + 2'd1 == rate_period(rate_eff)) ? 2'd0 : phase_reg + 2'd1;
        end
    end

    // Phase counter and latched rate
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            phase_reg <= 2'd0;
            rate_reg  <= RATE_1_2;
        end else begin
            phase_reg <= phase_next;
            rate_reg  <= rate_next;
        end
    end
`else
    logic unused_rate;

    assign unused_rate = ^Rate;
    assign keep        = '{keep_a: 1'b1, keep_b: 1'b1};
`endif

    // Pop the head on an output transfer, then load the kept bits of an
    // accepted input (the buffer is always empty after the pop when that happens)
    always_comb begin
        count_next = count_reg;
        buf_next   = buf_reg;
        if (out_fire) begin
            count_next = count_reg - 2'd1;
            buf_next   = {1'b0, buf_reg[1]};
        end
        if (accept) begin
            if (keep.keep_a && keep.keep_b) begin
                buf_next   = {b_bit, a_bit};
                count_next = 2'd2;
            end else if (keep.keep_a) begin
                buf_next   = {1'b0, a_bit};
                count_next = 2'd1;
            end else begin
                buf_next   = {1'b0, b_bit};
                count_next = 2'd1;
            end
        end
        if (Init) begin
            buf_next   = 2'b00;
            count_next = 2'd0;
        end
    end

    // Pending buffer registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count_reg <= 2'd0;
            buf_reg   <= 2'b00;
        end else begin
            count_reg <= count_next;
            buf_reg   <= buf_next;
        end
    end

endmodule
